// File: rtl/n64_pkg.sv
// Shared N64 controller definitions: button-word field bounds, event-entry width
// and the signed stick-axis distance helper.
package n64_pkg;

  localparam int unsigned BTN_HI     = 31;
  localparam int unsigned BTN_LO     = 16;
  localparam int unsigned STICK_X_HI = 15;
  localparam int unsigned STICK_X_LO = 8;
  localparam int unsigned STICK_Y_HI = 7;
  localparam int unsigned STICK_Y_LO = 0;

  localparam int unsigned BUTTON_W   = 32;
  localparam int unsigned TS_W_DEF   = 16;
  localparam int unsigned EVENT_W    = BUTTON_W + TS_W_DEF;

  // |a - b| of two signed 8-bit axes; 9-bit arithmetic so the range is 0..255
  function automatic logic [7:0] axis_delta(input logic [7:0] a, input logic [7:0] b);
    logic [8:0] d;
    logic [8:0] mag;
    d   = {a[7], a} - {b[7], b};
    mag = d[8] ? (~d + 9'd1) : d;
    return mag[7:0];
  endfunction

endpackage

// File: rtl/n64_button_event_queue_if.sv
// Poll-result input, queue control and event-head outputs of the button event queue.
interface n64_button_event_queue_if #(
  parameter int unsigned DEPTH    = 8,
  parameter int unsigned TS_WIDTH = 16
);
  logic                         sample_valid;
  logic [31:0]                  button_data;
  logic                         flush;
  logic                         pop;
  logic                         event_valid;
  logic [31:0]                  event_data;
  logic [TS_WIDTH-1:0]          event_ts;
  logic [$clog2(DEPTH+1)-1:0]   count;
  logic                         overflow;
  logic                         irq;

  modport master (
    output sample_valid, button_data, flush, pop,
    input  event_valid, event_data, event_ts, count, overflow, irq
  );

  modport slave (
    input  sample_valid, button_data, flush, pop,
    output event_valid, event_data, event_ts, count, overflow, irq
  );
endinterface

// File: rtl/n64_event_fifo.sv
// Synchronous first-word-fall-through FIFO with flush; head reads as zero when empty.
module n64_event_fifo #(
  parameter int unsigned WIDTH = 48,
  parameter int unsigned DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  logic [WIDTH-1:0]           wr_data,
  output logic [WIDTH-1:0]           rd_data,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_pop;
  logic             do_push;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty && !flush;
  assign do_push = push && !flush && (!full || do_pop);
  assign rd_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/n64_button_event_queue.sv
// Change-filtered, timestamped queue of N64 poll results for APB draining.
module n64_button_event_queue
  import n64_pkg::*;
#(
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned TS_WIDTH   = 16,
  parameter int unsigned DEADZONE   = 4,
  parameter int unsigned IRQ_THRESH = 4
) (
  input logic                      PCLK,
  input logic                      PRESERN,
  n64_button_event_queue_if.slave  bus
);
  localparam int unsigned CW = $clog2(DEPTH+1);
  localparam int unsigned EW = BUTTON_W + TS_WIDTH;

  logic [TS_WIDTH-1:0] ts;
  logic [31:0]         base;
  logic                base_valid;
  logic                overflow;
  logic                irq;

  logic [EW-1:0]       head;
  logic [CW-1:0]       count;
  logic                full;
  logic                empty;

  logic                change;
  logic                pop_ok;
  logic                accept;
  logic                push;
  logic                drop;
  logic [CW-1:0]       count_next;
  logic                overflow_next;

  always_comb begin
    change = !base_valid
          || (bus.button_data[BTN_HI:BTN_LO] != base[BTN_HI:BTN_LO])
          || (axis_delta(bus.button_data[STICK_X_HI:STICK_X_LO],
                         base[STICK_X_HI:STICK_X_LO]) > 8'(DEADZONE))
          || (axis_delta(bus.button_data[STICK_Y_HI:STICK_Y_LO],
                         base[STICK_Y_HI:STICK_Y_LO]) > 8'(DEADZONE));
  end

  // A same-cycle pop frees the slot, so a full queue still accepts the push
  assign pop_ok = bus.pop && !empty && !bus.flush;
  assign accept = bus.sample_valid && !bus.flush && change;
  assign push   = accept && (!full || pop_ok);
  assign drop   = accept && full && !pop_ok;

  assign count_next    = bus.flush ? '0 : (count + CW'(push) - CW'(pop_ok));
  assign overflow_next = !bus.flush && (overflow || drop);

  n64_event_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (PCLK),
    .rst_n   (PRESERN),
    .push    (push),
    .pop     (pop_ok),
    .flush   (bus.flush),
    .wr_data ({bus.button_data, ts}),
    .rd_data (head),
    .count   (count),
    .full    (full),
    .empty   (empty)
  );

  always_ff @(posedge PCLK or negedge PRESERN) begin
    if (!PRESERN) begin
      ts         <= '0;
      base       <= '0;
      base_valid <= 1'b0;
      overflow   <= 1'b0;
      irq        <= 1'b0;
    end else begin
      if (bus.sample_valid) ts <= ts + TS_WIDTH'(1);
      if (push) base <= bus.button_data;
      if (bus.flush)  base_valid <= 1'b0;
      else if (push)  base_valid <= 1'b1;
      overflow <= overflow_next;
      irq      <= (count_next >= CW'(IRQ_THRESH)) || overflow_next;
    end
  end

  assign bus.event_valid = !empty;
  assign bus.event_data  = head[EW-1:TS_WIDTH];
  assign bus.event_ts    = head[TS_WIDTH-1:0];
  assign bus.count       = count;
  assign bus.overflow    = overflow;
  assign bus.irq         = irq;

endmodule
